// File: rtl/bram_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : bram_pingpong_ctrl
// Brief   : Ping-pong sequencer for two bram18 line buffers (byte write, word read).
// Option  : define PPCTRL_OVERFLOW_EN for the sticky write-stall overflow flag
// Rev     : 1.0  initial release
// ============================================================================
module bram_pingpong_ctrl #(
   parameter int AW_A       = 11,
   parameter int AW_B       = 9,
   parameter int LINE_BYTES = 2048
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [7:0]      ext_mem_adr,
   input  logic            pix_valid,
   input  logic [7:0]      pix_data,
   output logic            pix_ready,
   input  logic            rd_req,
   output logic            rd_valid,
   output logic [31:0]     rd_data,
   output logic            ena,
   output logic            enb,
   output logic            wea1,
   output logic            wea2,
   output logic [AW_A-1:0] addra1,
   output logic [AW_A-1:0] addra2,
   output logic [7:0]      dina1,
   output logic [7:0]      dina2,
   output logic [AW_B-1:0] addrb1,
   output logic [AW_B-1:0] addrb2,
   input  logic [31:0]     doutb1,
   input  logic [31:0]     doutb2,
   output logic            busy,
   output logic            frame_done,
   output logic            overflow
);

   localparam logic [AW_A-1:0] WR_LAST = AW_A'(LINE_BYTES - 1);
   localparam logic [AW_B-1:0] RD_LAST = AW_B'(LINE_BYTES / 4 - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FILL   = 3'd1,
      S_STREAM = 3'd2,
      S_DRAIN  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      lines_q, lines_d;
   logic [7:0]      lines_wr_q, lines_wr_d;
   logic [7:0]      lines_rd_q, lines_rd_d;
   logic [AW_A-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW_B-1:0] rd_ptr_q, rd_ptr_d;
   logic [1:0]      full_q, full_d;
   logic            wr_bank_q, wr_bank_d;
   logic            rd_bank_q, rd_bank_d;
   logic            rd_valid_q, rd_valid_d;
   logic            rd_src_q, rd_src_d;
   logic            frame_done_q, frame_done_d;
   logic [AW_A-1:0] addra1_q, addra1_d, addra2_q, addra2_d;
   logic [7:0]      dina1_q, dina1_d, dina2_q, dina2_d;
   logic [AW_B-1:0] addrb1_q, addrb1_d, addrb2_q, addrb2_d;

   logic w_start_ok, w_wr_phase, w_rd_phase, w_ready, w_accept;
   logic w_issue, w_wr_last, w_rd_last, w_frame_last;

   assign w_start_ok   = start && (ext_mem_adr != 8'd0);
   assign w_wr_phase   = (state_q == S_FILL) || (state_q == S_STREAM);
   assign w_rd_phase   = w_wr_phase || (state_q == S_DRAIN);
   assign w_ready      = w_wr_phase && !full_q[wr_bank_q] && (lines_wr_q < lines_q);
   assign w_accept     = pix_valid && w_ready;
   assign w_issue      = w_rd_phase && rd_req && full_q[rd_bank_q];
   assign w_wr_last    = (wr_ptr_q == WR_LAST);
   assign w_rd_last    = (rd_ptr_q == RD_LAST);
   assign w_frame_last = w_issue && w_rd_last && (lines_rd_q == lines_q - 8'd1);

   always_comb begin
      state_d      = state_q;
      lines_d      = lines_q;
      lines_wr_d   = lines_wr_q;
      lines_rd_d   = lines_rd_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      full_d       = full_q;
      wr_bank_d    = wr_bank_q;
      rd_bank_d    = rd_bank_q;
      rd_valid_d   = w_issue;
      rd_src_d     = w_issue ? rd_bank_q : rd_src_q;
      frame_done_d = w_frame_last;
      // Idle BRAM ports keep presenting their last address/data.
      addra1_d     = (w_accept && !wr_bank_q) ? wr_ptr_q : addra1_q;
      addra2_d     = (w_accept &&  wr_bank_q) ? wr_ptr_q : addra2_q;
      dina1_d      = (w_accept && !wr_bank_q) ? pix_data : dina1_q;
      dina2_d      = (w_accept &&  wr_bank_q) ? pix_data : dina2_q;
      addrb1_d     = (w_issue  && !rd_bank_q) ? rd_ptr_q : addrb1_q;
      addrb2_d     = (w_issue  &&  rd_bank_q) ? rd_ptr_q : addrb2_q;

      case (state_q)
         S_IDLE: begin
            if (w_start_ok) begin
               state_d    = S_FILL;
               lines_d    = ext_mem_adr;
               lines_wr_d = 8'd0;
               lines_rd_d = 8'd0;
               wr_ptr_d   = '0;
               rd_ptr_d   = '0;
               full_d     = 2'b00;
               wr_bank_d  = 1'b0;
               rd_bank_d  = 1'b0;
            end
         end
         S_FILL: begin
            if (w_accept && w_wr_last) state_d = S_STREAM;
         end
         S_STREAM: begin
            if (w_frame_last)                state_d = S_DONE;
            else if (lines_wr_q == lines_q)  state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_frame_last) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Write and read always target different banks, so both updates may coexist.
      if (w_accept) begin
         if (w_wr_last) begin
            wr_ptr_d          = '0;
            full_d[wr_bank_q] = 1'b1;
            lines_wr_d        = lines_wr_q + 8'd1;
            wr_bank_d         = !wr_bank_q;
         end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
      end

      if (w_issue) begin
         if (w_rd_last) begin
            rd_ptr_d          = '0;
            full_d[rd_bank_q] = 1'b0;
            lines_rd_d        = lines_rd_q + 8'd1;
            rd_bank_d         = !rd_bank_q;
         end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         lines_q      <= 8'd0;
         lines_wr_q   <= 8'd0;
         lines_rd_q   <= 8'd0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         full_q       <= 2'b00;
         wr_bank_q    <= 1'b0;
         rd_bank_q    <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_src_q     <= 1'b0;
         frame_done_q <= 1'b0;
         addra1_q     <= '0;
         addra2_q     <= '0;
         dina1_q      <= 8'd0;
         dina2_q      <= 8'd0;
         addrb1_q     <= '0;
         addrb2_q     <= '0;
      end else begin
         state_q      <= state_d;
         lines_q      <= lines_d;
         lines_wr_q   <= lines_wr_d;
         lines_rd_q   <= lines_rd_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         full_q       <= full_d;
         wr_bank_q    <= wr_bank_d;
         rd_bank_q    <= rd_bank_d;
         rd_valid_q   <= rd_valid_d;
         rd_src_q     <= rd_src_d;
         frame_done_q <= frame_done_d;
         addra1_q     <= addra1_d;
         addra2_q     <= addra2_d;
         dina1_q      <= dina1_d;
         dina2_q      <= dina2_d;
         addrb1_q     <= addrb1_d;
         addrb2_q     <= addrb2_d;
      end
   end

`ifdef PPCTRL_OVERFLOW_EN
   logic overflow_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q <= 1'b0;
      end else if ((state_q == S_IDLE) && w_start_ok) begin
         overflow_q <= 1'b0;
      end else if (w_wr_phase && pix_valid && !w_ready) begin
         overflow_q <= 1'b1;
      end
   end

   assign overflow = overflow_q;
`else
   assign overflow = 1'b0;
`endif

   assign pix_ready  = w_ready;
   assign wea1       = w_accept && !wr_bank_q;
   assign wea2       = w_accept &&  wr_bank_q;
   assign addra1     = addra1_d;
   assign addra2     = addra2_d;
   assign dina1      = dina1_d;
   assign dina2      = dina2_d;
   assign addrb1     = addrb1_d;
   assign addrb2     = addrb2_d;
   assign busy       = (state_q != S_IDLE);
   assign ena        = (state_q != S_IDLE);
   assign enb        = (state_q != S_IDLE);
   assign rd_valid   = rd_valid_q;
   assign rd_data    = !rd_valid_q ? 32'd0 : (rd_src_q ? doutb2 : doutb1);
   assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_bram_pingpong_ctrl
// Brief   : Self-checking bench for bram_pingpong_ctrl against a line-count model.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bram_pingpong_ctrl;

   localparam int AW_A = 4;
   localparam int AW_B = 2;
   localparam int LB   = 16;
   localparam int WPL  = LB / 4;
`ifdef PPCTRL_OVERFLOW_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst, start, pix_valid, rd_req;
   logic [7:0]      ext_mem_adr, pix_data;
   logic            pix_ready, rd_valid, ena, enb, wea1, wea2, busy, frame_done, overflow;
   logic [31:0]     rd_data;
   logic [AW_A-1:0] addra1, addra2;
   logic [7:0]      dina1, dina2;
   logic [AW_B-1:0] addrb1, addrb2;
   logic [31:0]     doutb1 = 32'd0;
   logic [31:0]     doutb2 = 32'd0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bram_pingpong_ctrl #(.AW_A(AW_A), .AW_B(AW_B), .LINE_BYTES(LB)) dut (
      .clk(clk), .rst(rst), .start(start), .ext_mem_adr(ext_mem_adr),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
      .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
      .ena(ena), .enb(enb), .wea1(wea1), .wea2(wea2),
      .addra1(addra1), .addra2(addra2), .dina1(dina1), .dina2(dina2),
      .addrb1(addrb1), .addrb2(addrb2), .doutb1(doutb1), .doutb2(doutb2),
      .busy(busy), .frame_done(frame_done), .overflow(overflow)
   );

   // Two byte-write / word-read BRAMs with one cycle of read latency.
   logic [7:0] mem0 [2**AW_A];
   logic [7:0] mem1 [2**AW_A];
   always @(posedge clk) begin
      if (wea1) mem0[addra1] <= dina1;
      if (wea2) mem1[addra2] <= dina2;
      if (enb) begin
         doutb1 <= {mem0[{addrb1, 2'd3}], mem0[{addrb1, 2'd2}], mem0[{addrb1, 2'd1}], mem0[{addrb1, 2'd0}]};
         doutb2 <= {mem1[{addrb1 == addrb1 ? addrb2 : addrb2, 2'd3}], mem1[{addrb2, 2'd2}], mem1[{addrb2, 2'd1}], mem1[{addrb2, 2'd0}]};
      end
   end

   // Reference model: lines written/read counts and the frame's byte stream.
   bit          m_inframe = 0, m_donecyc = 0, m_rv = 0, m_fd = 0;
   int          m_lines = 0, m_w = 0, m_r = 0, m_b = 0, m_k = 0;
   logic [7:0]  m_bytes [$];
   logic [31:0] m_rdata = 32'd0;
   bit          exp_ready, exp_issue, exp_busy, exp_wea1, exp_wea2;

   task automatic drive(input bit r, input bit st, input logic [7:0] adr,
                        input bit pv, input logic [7:0] pd, input bit rq);
      rst = r; start = st; ext_mem_adr = adr;
      pix_valid = pv; pix_data = pd; rd_req = rq;
      @(negedge clk);
      exp_ready = m_inframe && ((m_w - m_r) < 2) && (m_w < m_lines);
      exp_issue = rq && m_inframe && ((m_w - m_r) >= 1);
      exp_busy  = m_inframe || m_donecyc;
      exp_wea1  = pv && exp_ready && (m_w % 2 == 0);
      exp_wea2  = pv && exp_ready && (m_w % 2 == 1);
   endtask

   task automatic advance();
      bit was_idle, acc, iss;
      @(posedge clk);
      was_idle  = !m_inframe && !m_donecyc;
      acc       = pix_valid && exp_ready;
      iss       = exp_issue;
      m_donecyc = 0;
      m_rv      = iss;
      m_fd      = 0;
      if (iss) begin
         int base;
         base    = m_r * LB + m_k * 4;
         m_rdata = {m_bytes[base+3], m_bytes[base+2], m_bytes[base+1], m_bytes[base]};
         m_fd    = (m_r == m_lines - 1) && (m_k == WPL - 1);
         m_k++;
         if (m_k == WPL) begin m_k = 0; m_r++; end
         if (m_fd) begin m_inframe = 0; m_donecyc = 1; end
      end
      if (acc) begin
         m_bytes.push_back(pix_data);
         m_b++;
         if (m_b == LB) begin m_b = 0; m_w++; end
      end
      if (was_idle && start && ext_mem_adr != 8'd0) begin
         m_inframe = 1; m_lines = int'(ext_mem_adr);
         m_w = 0; m_r = 0; m_b = 0; m_k = 0;
         m_bytes.delete();
      end
      if (rst) begin m_inframe = 0; m_donecyc = 0; m_rv = 0; m_fd = 0; end
      #1;
   endtask

   task automatic finish_frame(output int fd_cnt);
      fd_cnt = 0;
      for (int n = 0; n < 600 && (m_inframe || m_donecyc); n++) begin
         drive(0, 0, 8'd0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
         if (frame_done === 1'b1) fd_cnt++;
         advance();
      end
      total++;
      if (busy !== 1'b0 || m_inframe) begin
         bad++; $display("FAIL finish_timeout: busy=%0b want 0", busy);
      end
   endtask

   task automatic test_reset();
      drive(1, 0, 8'd0, 0, 8'd0, 0); advance();
      drive(1, 0, 8'd0, 0, 8'd0, 0); advance();
      drive(0, 0, 8'd0, 0, 8'd0, 0);
      total++;
      if ({busy, pix_ready, rd_valid, frame_done, wea1, wea2, ena, enb, overflow} !== 9'd0) begin
         bad++; $display("FAIL reset_flags: got %b want 0", {busy, pix_ready, rd_valid, frame_done, wea1, wea2, ena, enb, overflow});
      end
      total++;
      if (rd_data !== 32'd0 || {addra1, addra2, dina1, dina2, addrb1, addrb2} !== '0) begin
         bad++; $display("FAIL reset_buses: rd_data=%h addr/data=%h want 0", rd_data, {addra1, addra2, dina1, dina2, addrb1, addrb2});
      end
      advance();
      drive(0, 1, 8'd2, 0, 8'd0, 0); advance();
      for (int i = 0; i < 20; i++) begin drive(0, 0, 8'd0, 1, 8'(i), 0); advance(); end
      drive(1, 0, 8'd0, 0, 8'd0, 1); advance();
      drive(1, 0, 8'd0, 0, 8'd0, 0);
      total++;
      if (rd_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL reset_inflight: rd_valid=%0b busy=%0b want 0 0", rd_valid, busy);
      end
      advance();
      drive(0, 0, 8'd0, 1, 8'h55, 1);
      total++;
      if ({busy, pix_ready, wea1, wea2, rd_valid, frame_done, ena, enb} !== 8'd0 || rd_data !== 32'd0) begin
         bad++; $display("FAIL reset_midstream: flags=%b rd_data=%h want 0", {busy, pix_ready, wea1, wea2, rd_valid, frame_done, ena, enb}, rd_data);
      end
      advance();
   endtask

   task automatic test_single_line();
      logic [31:0] words [4];
      words = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
      drive(0, 1, 8'd1, 0, 8'd0, 0); advance();
      for (int i = 0; i < 16; i++) begin
         drive(0, 0, 8'd0, 1, 8'(i), 0);
         total++;
         if (pix_ready !== 1'b1 || wea1 !== 1'b1 || addra1 !== AW_A'(i)) begin
            bad++; $display("FAIL single_write[%0d]: ready=%0b wea1=%0b addra1=%0d want 1 1 %0d", i, pix_ready, wea1, addra1, i);
         end
         advance();
      end
      for (int i = 0; i <= 4; i++) begin
         drive(0, 0, 8'd0, 0, 8'd0, (i < 4) ? 1'b1 : 1'b0);
         if (i > 0) begin
            total++;
            if (rd_valid !== 1'b1 || rd_data !== words[i-1]) begin
               bad++; $display("FAIL single_word[%0d]: valid=%0b data=%h want 1 %h", i - 1, rd_valid, rd_data, words[i-1]);
            end
         end
         total++;
         if (frame_done !== (i == 4)) begin
            bad++; $display("FAIL single_frame_done[%0d]: got %0b want %0b", i, frame_done, i == 4);
         end
         advance();
      end
      drive(0, 0, 8'd0, 0, 8'd0, 0);
      total++;
      if (busy !== 1'b0 || frame_done !== 1'b0) begin
         bad++; $display("FAIL single_end: busy=%0b frame_done=%0b want 0 0", busy, frame_done);
      end
      advance();
   endtask

   task automatic test_stall();
      int fd;
      drive(0, 1, 8'd3, 0, 8'd0, 0); advance();
      for (int i = 0; i < 36; i++) begin
         drive(0, 0, 8'd0, 1, 8'($urandom), 0);
         total++;
         if (pix_ready !== (i < 32)) begin
            bad++; $display("FAIL stall_ready[cycle %0d]: got %0b want %0b", i + 1, pix_ready, i < 32);
         end
         advance();
      end
      for (int j = 0; j < 4; j++) begin
         drive(0, 0, 8'd0, 1, 8'($urandom), 1);
         total++;
         if (pix_ready !== 1'b0 || (j > 0 && rd_data !== m_rdata)) begin
            bad++; $display("FAIL stall_burst[%0d]: ready=%0b data=%h want 0 %h", j, pix_ready, rd_data, m_rdata);
         end
         advance();
      end
      drive(0, 0, 8'd0, 1, 8'($urandom), 0);
      total++;
      if (pix_ready !== 1'b1 || wea1 !== 1'b1) begin
         bad++; $display("FAIL stall_reopen: ready=%0b wea1=%0b want 1 1", pix_ready, wea1);
      end
      advance();
      finish_frame(fd);
      total++;
      if (fd != 1) begin bad++; $display("FAIL stall_frame_done: count=%0d want 1", fd); end
   endtask

   task automatic test_zero_lines();
      drive(0, 1, 8'd0, 1, 8'd0, 0); advance();
      drive(0, 0, 8'd0, 1, 8'd0, 1);
      total++;
      if (busy !== 1'b0 || pix_ready !== 1'b0 || wea1 !== 1'b0) begin
         bad++; $display("FAIL zero_lines: busy=%0b ready=%0b wea1=%0b want 0 0 0", busy, pix_ready, wea1);
      end
      advance();
      drive(0, 0, 8'd0, 0, 8'd0, 0);
      total++;
      if (rd_valid !== 1'b0) begin bad++; $display("FAIL zero_lines_rd: rd_valid=%0b want 0", rd_valid); end
      advance();
   endtask

   task automatic test_overflow();
      int fd;
      drive(0, 1, 8'd3, 0, 8'd0, 0); advance();
      drive(0, 0, 8'd0, 0, 8'd0, 0);
      total++;
      if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear_on_start: got %0b want 0", overflow); end
      advance();
      for (int i = 0; i < 32; i++) begin drive(0, 0, 8'd0, 1, 8'(i), 0); advance(); end
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 8'd0, 1, 8'hAA, 0);
         if (i > 0) begin
            total++;
            if (overflow !== OVF_EN) begin
               bad++; $display("FAIL ovf_hold[%0d]: got %0b want %0b", i, overflow, OVF_EN);
            end
         end
         advance();
      end
      finish_frame(fd);
      drive(0, 0, 8'd0, 0, 8'd0, 0);
      total++;
      if (overflow !== OVF_EN) begin bad++; $display("FAIL ovf_sticky_idle: got %0b want %0b", overflow, OVF_EN); end
      advance();
   endtask

   task automatic test_back_to_back();
      int fd;
      drive(0, 1, 8'd3, 0, 8'd0, 0); advance();
      for (int i = 0; i < 16; i++) begin
         drive(0, 0, 8'd0, 1, 8'(i), 0);
         total++;
         if (wea1 !== 1'b1 || wea2 !== 1'b0) begin
            bad++; $display("FAIL b2b_line0[%0d]: wea1=%0b wea2=%0b want 1 0", i, wea1, wea2);
         end
         advance();
      end
      for (int j = 0; j < 16; j++) begin
         drive(0, 0, 8'd0, 1, 8'(16 + j), (j >= 12) ? 1'b1 : 1'b0);
         total++;
         if (wea2 !== 1'b1 || wea1 !== 1'b0 || pix_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_line1[%0d]: wea1=%0b wea2=%0b ready=%0b want 0 1 1", j, wea1, wea2, pix_ready);
         end
         advance();
      end
      drive(0, 0, 8'd0, 1, 8'd32, 0);
      total++;
      if (pix_ready !== 1'b1 || wea1 !== 1'b1 || addra1 !== '0 || rd_data !== 32'h0F0E0D0C) begin
         bad++; $display("FAIL b2b_swap: ready=%0b wea1=%0b addra1=%0d data=%h want 1 1 0 0f0e0d0c", pix_ready, wea1, addra1, rd_data);
      end
      advance();
      finish_frame(fd);
      total++;
      if (fd != 1) begin bad++; $display("FAIL b2b_frame_done: count=%0d want 1", fd); end
   endtask

   task automatic test_random();
      for (int f = 0; f < 4; f++) begin
         drive(0, 1, 8'($urandom_range(1, 4)), 0, 8'd0, 0); advance();
         for (int n = 0; n < 800 && (m_inframe || m_donecyc); n++) begin
            bit pv, rq, st;
            logic [7:0] pd;
            pv = ($urandom_range(0, 9) < 7);
            rq = ($urandom_range(0, 1) == 1);
            st = ($urandom_range(0, 9) == 0);
            pd = 8'($urandom);
            drive(0, st, 8'($urandom_range(1, 5)), pv, pd, rq);
            total++;
            if (pix_ready !== exp_ready || busy !== exp_busy || wea1 !== exp_wea1 || wea2 !== exp_wea2) begin
               bad++; $display("FAIL rnd_ctrl: ready/busy/wea1/wea2=%b want %b", {pix_ready, busy, wea1, wea2}, {exp_ready, exp_busy, exp_wea1, exp_wea2});
            end
            total++;
            if (rd_valid !== m_rv || frame_done !== m_fd || (m_rv && rd_data !== m_rdata)) begin
               bad++; $display("FAIL rnd_read: valid=%0b done=%0b data=%h want %0b %0b %h", rd_valid, frame_done, rd_data, m_rv, m_fd, m_rdata);
            end
            if (exp_wea1 || exp_wea2) begin
               total++;
               if ((exp_wea1 ? addra1 : addra2) !== AW_A'(m_b) || (exp_wea1 ? dina1 : dina2) !== pd) begin
                  bad++; $display("FAIL rnd_write: addr=%0d data=%h want %0d %h", exp_wea1 ? addra1 : addra2, exp_wea1 ? dina1 : dina2, m_b, pd);
               end
            end
            advance();
         end
         total++;
         if (busy !== 1'b0 || m_inframe) begin bad++; $display("FAIL rnd_timeout[%0d]: busy=%0b want 0", f, busy); end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; ext_mem_adr = 8'd0;
      pix_valid = 1'b0; pix_data = 8'd0; rd_req = 1'b0;
      test_reset();
      test_single_line();
      test_stall();
      test_zero_lines();
      test_overflow();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
